// File: rtl/xor_pkg.sv
// Shared definitions for the XOR stream unit: mode encodings and packet state.
package xor_pkg;

    localparam logic [1:0] MODE_PAIR   = 2'd0;
    localparam logic [1:0] MODE_ACCUM  = 2'd1;
    localparam logic [1:0] MODE_PARITY = 2'd2;

    typedef enum logic {
        IDLE       = 1'b0,
        ACCUM_OPEN = 1'b1
    } xor_state_t;

endpackage

// File: rtl/xor_out_reg.sv
// One-entry output register for the XOR stream unit.
// Owns the result handshake and the upstream ready equation.
module xor_out_reg #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [W-1:0]     i_load_data,
    input  logic [CNT_W-1:0] i_load_beats,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_beats,
    output logic             in_ready
);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [CNT_W-1:0] r_beats;

    // Load a new result, or retire the held one once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_beats <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
            r_beats <= i_load_beats;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_beats = r_beats;
    assign in_ready  = !r_valid || out_ready;

endmodule

// File: rtl/xor_stream_unit.sv
// Registered XOR stream unit: per-beat XOR, packet XOR checksum, or per-beat parity
// under valid/ready handshakes on both sides.
module xor_stream_unit
    import xor_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_beats
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    xor_state_t       r_state;
    xor_state_t       w_state_nxt;
    logic [W-1:0]     r_acc;
    logic [W-1:0]     w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic [1:0]       w_mode_eff;
    logic [W-1:0]     w_xor;
    logic [W-1:0]     w_fold;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_load;
    logic [W-1:0]     w_load_data;
    logic [CNT_W-1:0] w_load_beats;

    // Beat count that sticks at the maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    function automatic logic parity_of(input logic [W-1:0] v);
        parity_of = ^v;
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_xor      = in_a ^ in_b;
    assign w_fold     = r_acc ^ w_xor;
    assign w_cnt_inc  = sat_inc(r_cnt);
    // An open packet keeps accumulating no matter what mode says.
    assign w_mode_eff = (r_state == ACCUM_OPEN) ? MODE_ACCUM : mode;

    // Next-state, accumulator and output-load decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_beats = '0;
        if (w_accept) begin
            case (w_mode_eff)
                MODE_ACCUM: begin
                    if (in_last) begin
                        w_load       = 1'b1;
                        w_load_data  = w_fold;
                        w_load_beats = w_cnt_inc;
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_acc_nxt    = w_fold;
                        w_cnt_nxt    = w_cnt_inc;
                        w_state_nxt  = ACCUM_OPEN;
                    end
                end
                MODE_PARITY: begin
                    w_load         = 1'b1;
                    w_load_data[0] = parity_of(w_xor);
                    w_load_beats   = CNT_W'(1);
                end
                default: begin
                    w_load       = 1'b1;
                    w_load_data  = w_xor;
                    w_load_beats = CNT_W'(1);
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Packet state, running checksum and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    xor_out_reg #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_load_data  (w_load_data),
        .i_load_beats (w_load_beats),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_beats    (out_beats),
        .in_ready     (in_ready)
    );

endmodule

// File: tb/tb_xor_stream_unit.sv
// Directed self-checking bench for xor_stream_unit (W = 8, CNT_W = 8).
module tb_xor_stream_unit;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_beats;

    int total;
    int bad;

    xor_stream_unit #(.W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beats (out_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, then step past the next rising edge.
    task automatic drive(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic last);
        mode     = m;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
        in_last = 1'b0; out_ready = 1'b1;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (out_beats !== 8'h00) begin bad++; $display("FAIL reset_beats got=%h exp=00", out_beats); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_pair();
        out_ready = 1'b1;
        drive(2'd0, 8'hF0, 8'h3C, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hCC) begin bad++; $display("FAIL pair_data got=%h exp=cc", out_data); end
        total++; if (out_beats !== 8'h01) begin bad++; $display("FAIL pair_beats got=%h exp=01", out_beats); end
        drive(2'd3, 8'h5A, 8'h0F, 1'b1);
        total++; if (out_data !== 8'h55 || out_beats !== 8'h01) begin
            bad++; $display("FAIL mode3_pair got=%h/%h exp=55/01", out_data, out_beats); end
        idle_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pair_consumed got=%b exp=0", out_valid); end
    endtask

    task automatic test_accum();
        out_ready = 1'b1;
        drive(2'd1, 8'h01, 8'h02, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL accum_beat1_valid got=%b exp=0", out_valid); end
        drive(2'd0, 8'h04, 8'h00, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL accum_beat2_valid got=%b exp=0", out_valid); end
        drive(2'd1, 8'h80, 8'h10, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL accum_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'h97) begin bad++; $display("FAIL accum_data got=%h exp=97", out_data); end
        total++; if (out_beats !== 8'h03) begin bad++; $display("FAIL accum_beats got=%h exp=03", out_beats); end
        drive(2'd1, 8'h22, 8'h01, 1'b1);
        total++; if (out_data !== 8'h23 || out_beats !== 8'h01) begin
            bad++; $display("FAIL accum_single got=%h/%h exp=23/01", out_data, out_beats); end
        idle_cycle();
    endtask

    task automatic test_parity();
        out_ready = 1'b1;
        drive(2'd2, 8'h07, 8'h00, 1'b0);
        total++; if (out_data !== 8'h01 || out_beats !== 8'h01) begin
            bad++; $display("FAIL parity_odd got=%h/%h exp=01/01", out_data, out_beats); end
        drive(2'd2, 8'h03, 8'h00, 1'b0);
        total++; if (out_data !== 8'h00 || out_valid !== 1'b1) begin
            bad++; $display("FAIL parity_even got=%h/%b exp=00/1", out_data, out_valid); end
        idle_cycle();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(2'd0, 8'hAA, 8'h0F, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=0/1/a5", i, in_ready, out_valid, out_data); end
            @(posedge clk);
            #1;
        end
        // A stalled beat must not be taken.
        in_valid = 1'b1; mode = 2'd0; in_a = 8'hFF; in_b = 8'h00; in_last = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL bp_stall_ignored got=%h exp=a5", out_data); end
        out_ready = 1'b1; in_a = 8'h12; in_b = 8'h34;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_comb got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 8'h26 || out_beats !== 8'h01) begin
            bad++; $display("FAIL bp_replace got=%b/%h/%h exp=1/26/01", out_valid, out_data, out_beats); end
        idle_cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        int early;
        early = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 299; i++) begin
            drive(2'd1, 8'h01, 8'h00, 1'b0);
            if (out_valid !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL sat_no_early got=%0d exp=0", early); end
        drive(2'd1, 8'h01, 8'h00, 1'b1);
        total++; if (out_beats !== 8'hFF) begin bad++; $display("FAIL sat_beats got=%h exp=ff", out_beats); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL sat_data got=%h exp=00", out_data); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(2'd0, 8'h3C, 8'h00, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_beats !== 8'h00) begin
            bad++; $display("FAIL rst_async got=%b/%h/%h exp=0/00/00", out_valid, out_data, out_beats); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drive(2'd1, 8'h0F, 8'h00, 1'b0);
        drive(2'd1, 8'h30, 8'h00, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(2'd1, 8'h55, 8'h00, 1'b1);
        total++; if (out_valid !== 1'b1 || out_data !== 8'h55 || out_beats !== 8'h01) begin
            bad++; $display("FAIL rst_fresh got=%b/%h/%h exp=1/55/01", out_valid, out_data, out_beats); end
        idle_cycle();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pair();
        test_accum();
        test_parity();
        test_back_pressure();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_stream_unit.md
Name: xor_stream_unit

Overview:
- Parametrised, registered successor to the team's two-input XOR gate.
- Combines two W-bit operand streams under a valid/ready handshake, in one of three modes: per-beat XOR, packet-wide XOR checksum accumulation, or per-beat parity.
- Sits between operand producers and checksum/compare logic.
- Has a one-deep registered output stage, so back-pressure is handled without losing data.

Parameters:
- W, 8: operand and result width in bits (W >= 1).
- CNT_W, 8: width of the packet beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  operating mode: 0 = PAIR, 1 = ACCUM, 2 = PARITY, 3 = reserved, treated as PAIR.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_last  input  1  final beat of packet; only meaningful in ACCUM mode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  result word.
- out_beats  output  CNT_W  number of beats folded into the result.

Behaviour:
- Reset: the asynchronous active-low reset is applied immediately, whatever is in progress, and drops any partial packet. Values during reset:
  - out_valid = 0, out_data = 0, out_beats = 0
  - accumulator = 0, beat counter = 0, state = IDLE
  - in_ready = 1 once reset deasserts.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready, so full throughput of one beat per cycle holds under a continuous out_ready.
  - out_valid and out_data hold stable while out_valid && !out_ready.
- States:
  - IDLE: no packet is open.
  - ACCUM_OPEN: an ACCUM packet has started but in_last has not yet been accepted.
- Mode sampling:
  - In IDLE, mode is sampled on every accepted beat.
  - In ACCUM_OPEN, mode is ignored; every beat is accumulated until in_last.
- PAIR (and mode 3): an accepted beat loads out_data = in_a ^ in_b and out_beats = 1, and sets out_valid on the next edge (latency 1). in_last is ignored.
- PARITY: an accepted beat loads out_data = {W-1 zeros, ^(in_a ^ in_b)} and out_beats = 1 (latency 1).
- ACCUM, non-last beat:
  - acc <= acc ^ in_a ^ in_b
  - cnt <= sat(cnt + 1)
  - state moves to ACCUM_OPEN; no output is produced, and in_ready stays governed by the rule above.
- ACCUM, last beat:
  - out_data <= acc ^ in_a ^ in_b
  - out_beats <= sat(cnt + 1)
  - out_valid <= 1; acc and cnt are cleared; state returns to IDLE.
  - A single-beat packet (in_last on its first beat) outputs in_a ^ in_b with out_beats = 1.
- Counter: out_beats saturates at 2^CNT_W - 1 and never wraps. The XOR accumulation itself continues regardless of count.
- Simultaneous events: consuming a held result and accepting a new beat in the same cycle is legal. The new result replaces the old one with no bubble.
- Idle input (in_valid = 0): all state holds.

Decomposition:
- Shared package xor_pkg holds:
  - the mode encoding constants MODE_PAIR = 2'd0, MODE_ACCUM = 2'd1, MODE_PARITY = 2'd2;
  - the state enum {IDLE, ACCUM_OPEN}.
- One natural sub-module, xor_out_reg: the one-entry output register holding out_valid, out_data and out_beats, plus the in_ready equation.
- The datapath is a single W-bit XOR plus a reduction XOR and needs no further split.

Test Plan (W = 8, CNT_W = 8):
- PAIR: in_a = 8'hF0, in_b = 8'h3C, out_ready = 1 → next cycle out_valid = 1, out_data = 8'hCC, out_beats = 1.
- ACCUM with back-to-back beats:
  - Beats (a, b) = (8'h01, 8'h02), (8'h04, 8'h00), (8'h80, 8'h10 with in_last) → one result, out_data = 8'h97, out_beats = 3.
  - Changing mode to PAIR on the middle beat has no effect.
- PARITY: in_a = 8'h07, in_b = 8'h00 → out_data = 8'h01; in_a = 8'h03, in_b = 8'h00 → out_data = 8'h00.
- Back-pressure:
  - Hold out_ready = 0 with a PAIR result pending → in_ready = 0, and out_data stays stable for 5 cycles.
  - Raise out_ready together with a new beat → the old result is consumed and the new result appears on the next edge.
- Saturation: an ACCUM packet of 300 beats, all with a = 8'h01, b = 8'h00 → out_beats = 8'hFF, out_data = 8'h00 (even count).
- Reset mid-packet:
  - Assert rst_n = 0 after 2 ACCUM beats → out_valid = 0 immediately.
  - After release, a single-beat ACCUM (8'h55, 8'h00, last) → out_data = 8'h55, out_beats = 1.
